// File: rtl/uart_pkg.sv
// Purpose: shared 8N1 UART definitions (receiver FSM states, frame shape, bit timing).
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Shared by transmitter and receiver so both ends agree on bit timing.
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Purpose: synchronous show-ahead FIFO; head entry is visible on dout_o while not empty.
// Latency: push visible on dout_o/empty_o one cycle after the push edge.
// Backpressure: push while full is accepted only alongside a pop, otherwise ignored.
// Ports: clk_i/rst_i (sync, active-high), push_i/din_i/full_o write side,
//        pop_i/dout_o/empty_o read side.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t count_q, count_d;
    logic do_push, do_pop;

    assign full_o  = (count_q == cnt_t'(DEPTH));
    assign empty_o = (count_q == '0);
    assign dout_o  = mem_q[rd_ptr_q];

    // Both decisions use start-of-cycle occupancy; a pop frees the slot a
    // full-FIFO push needs in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
    assign count_d  = count_q + cnt_t'(do_push) - cnt_t'(do_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// Purpose: 8N1 UART receiver with mid-bit sampling, stop-bit check and a show-ahead byte FIFO.
// Latency: rx_valid_o rises 99 clocks after the rx_i falling edge (default params).
// Backpressure: consumer holds rx_ready_i low to keep bytes queued; a byte arriving
//               with the FIFO full and no pop is dropped and overrun_o pulses.
// Ports: clk_i, rst_i (sync, active-high), rx_i (async line), rx_data_o/rx_valid_o/
//        rx_ready_i (byte handshake), framing_err_o, overrun_o (1-cycle pulses), busy_o.
module uart_rx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000,
    parameter int BAUD         = 9600,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD),
    parameter int HALF_BIT     = CLKS_PER_BIT / 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 framing_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    typedef logic [CW-1:0] cnt_t;
    typedef logic [BW-1:0] bit_t;

    logic                 sync1_q, rxs_q;
    rx_state_e            state_q, state_d;
    cnt_t                 cnt_q, cnt_d;
    bit_t                 bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push_q, push_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 fifo_full, fifo_empty, pop;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_i;
            rxs_q   <= sync1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!rxs_q) begin
                    state_d   = START;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            START: begin
                if (cnt_q == cnt_t'(HALF_BIT - 1)) begin
                    // Still low at mid start bit: real frame. High: glitch, drop silently.
                    if (!rxs_q) begin
                        state_d   = DATA;
                        cnt_d     = '0;
                        bit_idx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            DATA: begin
                if (cnt_q == cnt_t'(CLKS_PER_BIT - 1)) begin
                    cnt_d            = '0;
                    shift_d[bit_idx_q] = rxs_q;
                    if (bit_idx_q == bit_t'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + bit_t'(1);
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            STOP: begin
                // Leaving at mid stop bit lets the next start edge be caught
                // even with zero idle time between frames.
                if (cnt_q == cnt_t'(CLKS_PER_BIT - 1)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rxs_q) begin
                        push_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop   = rx_valid_o && rx_ready_i;
    // Registered push reaches the FIFO one cycle after the stop sample, so the
    // overrun decision is made in that same cycle.
    assign ovr_d = push_q && fifo_full && !pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            push_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            push_q    <= push_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    // shift_q is not touched again until the next frame's first data sample,
    // so it is still the completed byte when push_q is high.
    uart_rx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_q),
        .din_i   (shift_q),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .dout_o  (rx_data_o),
        .empty_o (fifo_empty)
    );

    assign rx_valid_o    = !fifo_empty;
    assign framing_err_o = ferr_q;
    assign overrun_o     = ovr_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Purpose: self-checking bench for uart_rx_buffered using a queue-level reference model.
// Latency: model places each byte 99 edges after the frame's falling edge.
// Backpressure: directed rx_ready patterns exercise hold, drain, overrun and push-with-pop.
`timescale 1ns/1ps
module tb_uart_rx_buffered;

    localparam int CPB = 10;

    logic       clk = 1'b0;
    logic       rst, rx, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, framing_err, overrun, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ferr_cnt = 0;
    int ovr_cnt  = 0;
    bit chk_en   = 1'b0;

    typedef struct packed {
        int         edge_n;
        logic       ferr;
        logic [7:0] b;
    } ev_t;

    ev_t        evq[$];
    logic [7:0] mq[$];
    bit         ferr_exp, ovr_exp;

    always #5 clk = ~clk;

    uart_rx_buffered dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rx_i          (rx),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .rx_ready_i    (rx_ready),
        .framing_err_o (framing_err),
        .overrun_o     (overrun),
        .busy_o        (busy)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a byte queue plus a schedule of frame outcomes.
    always @(posedge clk) begin
        int  e;
        bit  full, pop;
        ev_t ev;
        e        = cyc + 1;
        ferr_exp = 1'b0;
        ovr_exp  = 1'b0;
        if (rst) begin
            mq.delete();
            evq.delete();
        end else begin
            full = (mq.size() == 4);
            pop  = (mq.size() > 0) && (rx_ready === 1'b1);
            if (pop) void'(mq.pop_front());
            while (evq.size() > 0 && evq[0].edge_n <= e) begin
                ev = evq.pop_front();
                if (ev.ferr) ferr_exp = 1'b1;
                else if (!full || pop) mq.push_back(ev.b);
                else ovr_exp = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (framing_err === 1'b1) ferr_cnt++;
        if (overrun === 1'b1) ovr_cnt++;
        if (chk_en) begin
            chk("model_valid", {7'd0, rx_valid}, {7'd0, mq.size() > 0});
            if (mq.size() > 0) chk("model_data", rx_data, mq[0]);
            chk("model_ferr", {7'd0, framing_err}, {7'd0, ferr_exp});
            chk("model_ovr", {7'd0, overrun}, {7'd0, ovr_exp});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; the falling edge is first sampled on the next one.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        ev_t ev;
        ev.edge_n = cyc + (stop_ok ? 99 : 98);
        ev.ferr   = !stop_ok;
        ev.b      = b;
        evq.push_back(ev);
        rx = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) tick();
        end
        rx = stop_ok;
        repeat (CPB) tick();
        rx = 1'b1;
    endtask

    task automatic pop_expect(input logic [7:0] b);
        chk("pop_valid", {7'd0, rx_valid}, 8'd1);
        chk("pop_data", rx_data, b);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        int f0, o0;
        rst = 1'b1; rx = 1'b1; rx_ready = 1'b0;
        repeat (3) tick();
        chk("rst_valid", {7'd0, rx_valid}, 8'd0);
        chk("rst_data", rx_data, 8'h00);
        chk("rst_ferr", {7'd0, framing_err}, 8'd0);
        chk("rst_ovr", {7'd0, overrun}, 8'd0);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        repeat (5) tick();

        // Single byte with exact latency.
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (98) tick();
                chk("lat_before", {7'd0, rx_valid}, 8'd0);
                tick();
                chk("lat_valid", {7'd0, rx_valid}, 8'd1);
                chk("lat_data", rx_data, 8'hA5);
            end
        join
        repeat (3) tick();
        chk("hold_data", rx_data, 8'hA5);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("pop_empty", {7'd0, rx_valid}, 8'd0);
        repeat (10) tick();

        // Framing error then recovery.
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0);
        repeat (200) tick();
        chk("ferr_pulses", 8'(ferr_cnt - f0), 8'd1);
        chk("ferr_novalid", {7'd0, rx_valid}, 8'd0);
        send_frame(8'h81, 1'b1);
        repeat (3) tick();
        pop_expect(8'h81);

        // Start-bit glitch.
        f0 = ferr_cnt; o0 = ovr_cnt;
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        chk("glitch_busy", {7'd0, busy}, 8'd1);
        repeat (10) tick();
        chk("glitch_idle", {7'd0, busy}, 8'd0);
        chk("glitch_novalid", {7'd0, rx_valid}, 8'd0);
        chk("glitch_flags", 8'(ferr_cnt - f0 + ovr_cnt - o0), 8'd0);
        send_frame(8'h55, 1'b1);
        repeat (3) tick();
        pop_expect(8'h55);

        // Overrun with five back-to-back frames.
        o0 = ovr_cnt;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        repeat (5) tick();
        chk("ovr_pulses", 8'(ovr_cnt - o0), 8'd1);
        for (int i = 1; i <= 4; i++) pop_expect(8'(i));
        chk("ovr_drained", {7'd0, rx_valid}, 8'd0);

        // Full FIFO with a pop in the push cycle.
        o0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
        fork
            send_frame(8'h05, 1'b1);
            begin
                repeat (98) tick();
                chk("pp_head", rx_data, 8'h01);
                rx_ready = 1'b1;
                tick();
                rx_ready = 1'b0;
            end
        join
        repeat (3) tick();
        chk("pp_no_ovr", 8'(ovr_cnt - o0), 8'd0);
        for (int i = 2; i <= 5; i++) pop_expect(8'(i));
        chk("pp_drained", {7'd0, rx_valid}, 8'd0);

        // Reset in the middle of data bit 4 of 0xF0, with a byte already queued.
        send_frame(8'h99, 1'b1);
        repeat (3) tick();
        rx = 1'b0;
        repeat (50) tick();
        rx = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_valid", {7'd0, rx_valid}, 8'd0);
        chk("mid_rst_data", rx_data, 8'h00);
        chk("mid_rst_busy", {7'd0, busy}, 8'd0);
        chk("mid_rst_flags", {6'd0, framing_err, overrun}, 8'd0);
        rst = 1'b0;
        repeat (60) tick();
        f0 = ferr_cnt; o0 = ovr_cnt;
        send_frame(8'h0F, 1'b1);
        repeat (3) tick();
        pop_expect(8'h0F);
        chk("rst_rx_flags", 8'(ferr_cnt - f0 + ovr_cnt - o0), 8'd0);

        // Back-to-back with no idle gap.
        f0 = ferr_cnt;
        send_frame(8'hDE, 1'b1);
        send_frame(8'hAD, 1'b1);
        repeat (3) tick();
        pop_expect(8'hDE);
        pop_expect(8'hAD);
        chk("b2b_no_ferr", 8'(ferr_cnt - f0), 8'd0);
        repeat (5) tick();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_rx_buffered.md
Name: uart_rx_buffered

Overview:
- Standalone UART receiver for the 8N1 frames our UART transmitter produces: one start bit (low), 8 data bits LSB first, one stop bit (high), idle high.
- Synchronises the asynchronous rx pin, detects a valid start bit and samples each bit at mid-bit.
- Checks the stop bit and pushes good bytes into a small show-ahead FIFO that the consumer drains with a valid/ready handshake.
- Sits between the board rx pin and the command/data consumer logic.

Parameters:
- CLK_FREQ, 100_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s.
- CLKS_PER_BIT, CLK_FREQ/BAUD (=10), clocks per bit; integer division; must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2 (=5), clocks from start-bit detection to the start-bit mid-sample.
- FIFO_DEPTH, 4, number of received bytes buffered; power of two, >= 2.

Ports:
- clk, input, 1, system clock; all logic on the rising edge.
- rst, input, 1, synchronous active-high reset.
- rx, input, 1, asynchronous serial line; idles high.
- rx_data, output, 8, byte at the FIFO head; valid only while rx_valid=1.
- rx_valid, output, 1, FIFO not empty.
- rx_ready, input, 1, consumer accepts the head byte when rx_valid & rx_ready.
- framing_err, output, 1, 1-cycle pulse: stop bit sampled low; byte discarded.
- overrun, output, 1, 1-cycle pulse: good byte dropped because the FIFO was full.
- busy, output, 1, high whenever the FSM is not in IDLE.

Behaviour:
- Synchroniser: rx passes through 2 flops; both reset to 1. The FSM uses only the synchronised value rxs.
- Reset values: FIFO empty, rx_valid=0, rx_data=0, framing_err=0, overrun=0, busy=0, FSM=IDLE, all counters 0.
- Reset is honoured mid-frame: the partial byte is discarded and the FSM waits in IDLE for the next falling edge.
- FSM state IDLE: if rxs==0, go to START and clear the bit counter.
- FSM state START: count up to HALF_BIT-1, then sample rxs.
  - rxs==0: go to DATA, clear the counter and bit index.
  - rxs==1 (glitch): return to IDLE with no flag.
- FSM state DATA: every CLKS_PER_BIT clocks, sample rxs into shift[bit_index] (LSB first). After bit_index 7 is sampled, go to STOP.
- FSM state STOP: after CLKS_PER_BIT clocks, sample rxs.
  - rxs==1: push the byte.
  - rxs==0: pulse framing_err for one cycle, no push.
  - In both cases return to IDLE in the same cycle. Back-to-back frames are therefore accepted after only a half stop bit.
- Framing error recovery: if the line is still low when the FSM reaches IDLE, the next cycle is treated as a start bit (normal resync).
- FIFO rules:
  - Push and pop are evaluated against the occupancy at the start of the cycle.
  - Pop occurs when rx_valid & rx_ready.
  - Push when not full: accepted.
  - Push when full with a simultaneous pop: accepted; occupancy stays FIFO_DEPTH.
  - Push when full without a pop: byte dropped, overrun pulses for one cycle, contents unchanged.
  - Pop when empty: ignored.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy is log2(FIFO_DEPTH)+1 bits.
- Latency: rx_valid rises the cycle after the stop-bit sample (push registered). rx_data is combinational from the head entry.
- End-to-end timing, defaults, from the rx pin falling edge to rx_valid=1: 2 (sync) + 1 (IDLE) + 5 + 80 + 10 + 1 = 99 cycles.
- rx_data and rx_valid stay stable while rx_valid=1 and rx_ready=0.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state encoding (IDLE, START, DATA, STOP).
  - The 8N1 frame constants DATA_BITS=8 and STOP_BITS=1.
  - A clks_per_bit(clk_freq, baud) function, so this block and the UART transmitter use identical bit timing.
- One sub-module, uart_rx_fifo: synchronous show-ahead FIFO with parameters WIDTH and DEPTH and ports push, din, full, pop, dout, empty.
- The synchroniser and FSM stay in the top module.

Test Plan:
- Single byte: drive frame 0xA5 at 10 clks/bit with rx_ready=0 → rx_valid=1 with rx_data=0xA5 99 cycles after the falling edge. Assert rx_ready for 1 cycle → rx_valid=0.
- Framing error: frame 0x3C with the stop bit held low → framing_err pulses 1 cycle, rx_valid stays 0. Then a good frame 0x81 → rx_data=0x81.
- Glitch rejection: rx low for 3 cycles, then high → busy rises then falls, no valid, no flags. Follow with frame 0x55 → received correctly.
- Overrun and simultaneous push/pop:
  - Send 0x01..0x05 back-to-back with rx_ready=0 → 4 bytes stored, overrun pulses on the 5th.
  - Drain → reads 0x01, 0x02, 0x03, 0x04.
  - Repeat with FIFO full and rx_ready=1 in the push cycle → no overrun, occupancy stays 4.
- Reset mid-frame: assert rst during data bit 4 of frame 0xF0 → all outputs at reset values next cycle. Next frame 0x0F → rx_data=0x0F, no flags.
- Back-to-back with minimum gap: frames 0xDE then 0xAD with no idle time → both received in order, no framing_err.
